maze_player_ctrl: RTL



---
 rtl/maze_player_ctrl.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/maze_player_ctrl.sv
// Maze player controller: debounces the Basys buttons, arbitrates to a single move,
// and walks the player across a fixed wall grid.
//   state | meaning
//   IDLE  | waiting for a button strobe
//   CHECK | target latched, wall bit being looked up
//   MOVE  | player/move_pulse just updated
//   WIN   | player on goal, only centre restarts
module maze_player_ctrl #(
  parameter int                         DEBOUNCE_CYCLES = 2000000,
  parameter int                         GRID_W          = 8,
  parameter int                         GRID_H          = 8,
  parameter logic [GRID_W*GRID_H-1:0]   MAZE_WALLS      = '0,
  parameter int                         START_X         = 0,
  parameter int                         START_Y         = 0,
  parameter int                         GOAL_X          = 7,
  parameter int                         GOAL_Y          = 7
) (
  input  logic                        basys_clock,
  input  logic                        reset,
  input  logic                        enable,
  input  logic [4:0]                  pb,
  output logic [$clog2(GRID_W)-1:0]   player_x,
  output logic [$clog2(GRID_H)-1:0]   player_y,
  output logic                        solved,
  output logic [7:0]                  move_count,
  output logic                        move_pulse,
  output logic                        bump_pulse
);

  localparam int XW = $clog2(GRID_W);
  localparam int YW = $clog2(GRID_H);
  localparam int IW = $clog2(GRID_W*GRID_H);
  localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, CHECK, MOVE, WIN} state_t;

  logic [4:0]    sync1;
  logic [4:0]    sync2;
  logic [4:0]    stable;
  logic [4:0]    stable_d;
  logic [CW-1:0] db_cnt [5];
  logic [4:0]    strobe;

  always_ff @(posedge basys_clock) begin
    if (reset) begin
      sync1    <= '0;
      sync2    <= '0;
      stable   <= '0;
      stable_d <= '0;
      for (int i = 0; i < 5; i++) db_cnt[i] <= '0;
    end else begin
      sync1    <= pb;
      sync2    <= sync1;
      stable_d <= stable;
      for (int i = 0; i < 5; i++) begin
        if (sync2[i] == stable[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
          stable[i] <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + CW'(1);
        end
      end
    end
  end

  // press only: releases never strobe
  assign strobe = stable & ~stable_d;

  state_t        state, state_next;
  logic [XW-1:0] target_x, tx_next, x_next, dir_x;
  logic [YW-1:0] target_y, ty_next, y_next, dir_y;
  logic [7:0]    count_next;
  logic          solved_next, move_next, bump_next;
  logic          dir_any, at_edge;
  logic [IW-1:0] cell_idx;
  logic          wall_hit;

  // Winner among directions is up > down > left > right; centre is handled ahead of this.
  always_comb begin
    dir_any = strobe[1] | strobe[4] | strobe[2] | strobe[3];
    at_edge = 1'b0;
    dir_x   = player_x;
    dir_y   = player_y;
    if (strobe[1]) begin
      at_edge = (player_y == '0);
      dir_y   = player_y - YW'(1);
    end else if (strobe[4]) begin
      at_edge = (player_y == YW'(GRID_H - 1));
      dir_y   = player_y + YW'(1);
    end else if (strobe[2]) begin
      at_edge = (player_x == '0);
      dir_x   = player_x - XW'(1);
    end else if (strobe[3]) begin
      at_edge = (player_x == XW'(GRID_W - 1));
      dir_x   = player_x + XW'(1);
    end
  end

  assign cell_idx = IW'(target_y) * IW'(GRID_W) + IW'(target_x);
  assign wall_hit = MAZE_WALLS[cell_idx];

  always_comb begin
    state_next  = state;
    x_next      = player_x;
    y_next      = player_y;
    tx_next     = target_x;
    ty_next     = target_y;
    count_next  = move_count;
    solved_next = solved;
    move_next   = 1'b0;
    bump_next   = 1'b0;
    case (state)
      IDLE, WIN: begin
        if (strobe[0]) begin
          x_next      = XW'(START_X);
          y_next      = YW'(START_Y);
          count_next  = '0;
          solved_next = 1'b0;
          state_next  = IDLE;
        end else if (state == IDLE && enable && dir_any) begin
          if (at_edge) begin
            bump_next = 1'b1;
          end else begin
            tx_next    = dir_x;
            ty_next    = dir_y;
            state_next = CHECK;
          end
        end
      end
      CHECK: begin
        // Player and pulse are registered here so they are visible while in MOVE.
        if (wall_hit) begin
          bump_next  = 1'b1;
          state_next = IDLE;
        end else begin
          x_next     = target_x;
          y_next     = target_y;
          move_next  = 1'b1;
          count_next = (move_count == 8'hFF) ? move_count : move_count + 8'd1;
          if (target_x == XW'(GOAL_X) && target_y == YW'(GOAL_Y)) solved_next = 1'b1;
          state_next = MOVE;
        end
      end
      MOVE: begin
        state_next = solved ? WIN : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge basys_clock) begin
    if (reset) begin
      state      <= IDLE;
      player_x   <= XW'(START_X);
      player_y   <= YW'(START_Y);
      target_x   <= '0;
      target_y   <= '0;
      move_count <= '0;
      solved     <= 1'b0;
      move_pulse <= 1'b0;
      bump_pulse <= 1'b0;
    end else begin
      state      <= state_next;
      player_x   <= x_next;
      player_y   <= y_next;
      target_x   <= tx_next;
      target_y   <= ty_next;
      move_count <= count_next;
      solved     <= solved_next;
      move_pulse <= move_next;
      bump_pulse <= bump_next;
    end
  end

endmodule
